// File: rtl/parity_arbiter_if.sv
// parity_arbiter_if: request/result bus of the packet parity arbiter.
//   in_valid/in_data/in_last : per-requester byte stream (requester i at
//                              in_data[i*DATA_W +: DATA_W])
//   in_ready                 : per-requester byte accept
//   res_valid/res_ready      : result handshake
//   res_parity/res_id/res_len: packet parity, owner index, byte count
// master = requester/consumer side, slave = arbiter side.
interface parity_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        in_valid;
  logic [N_REQ*DATA_W-1:0] in_data;
  logic [N_REQ-1:0]        in_last;
  logic [N_REQ-1:0]        in_ready;
  logic                    res_valid;
  logic                    res_ready;
  logic                    res_parity;
  logic [1:0]              res_id;
  logic [7:0]              res_len;

  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_parity, res_id, res_len
  );

  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_parity, res_id, res_len
  );
endinterface

// File: rtl/parity_arbiter.sv
// parity_arbiter: round-robin arbiter that grants one requester at a time,
// accumulates the XOR parity and length of its packet, and presents the
// result on a valid/ready handshake.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : parity_arbiter_if slave modport (request streams + result)
// All outputs are driven straight from registers.
module parity_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  parity_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [1:0]         grant_r, grant_s;
  logic [1:0]         last_grant_r, last_grant_s;
  logic               acc_r, acc_s;
  logic [7:0]         len_r, len_s;
  logic [N_REQ-1:0]   in_ready_r, in_ready_s;
  logic               res_valid_r, res_valid_s;
  logic               res_parity_r, res_parity_s;
  logic [1:0]         res_id_r, res_id_s;
  logic [7:0]         res_len_r, res_len_s;

  logic [1:0]         rr_pick_s;
  logic               any_valid_s;
  logic               accept_s;
  logic [DATA_W-1:0]  byte_s;
  logic               acc_nxt_s;
  logic [7:0]         len_nxt_s;

  function automatic logic parity_f(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  function automatic logic [7:0] sat_inc_f(input logic [7:0] v);
    return (v == 8'd255) ? 8'd255 : v + 8'd1;
  endfunction

  function automatic logic [N_REQ-1:0] onehot_f(input logic [1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = {N_REQ{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Round-robin pick: walk offsets from farthest to nearest so the nearest
  // valid requester after last_grant is the one left standing.
  always_comb begin
    int idx_v;
    rr_pick_s = last_grant_r;
    idx_v     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_v = (int'(last_grant_r) + 32'sd1 + k) % N_REQ;
      if (bus.in_valid[idx_v]) begin
        rr_pick_s = 2'(idx_v);
      end else begin
        rr_pick_s = rr_pick_s;
      end
    end
  end

  // Datapath helpers for the granted requester's current byte.
  always_comb begin
    any_valid_s = |bus.in_valid;
    byte_s      = bus.in_data[int'(grant_r)*DATA_W +: DATA_W];
    accept_s    = (state_r == ACCUM) && bus.in_valid[grant_r] && in_ready_r[grant_r];
    acc_nxt_s   = acc_r ^ parity_f(byte_s);
    len_nxt_s   = sat_inc_f(len_r);
  end

  // Next-state and next-output logic; everything holds unless changed.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    acc_s        = acc_r;
    len_s        = len_r;
    in_ready_s   = in_ready_r;
    res_valid_s  = res_valid_r;
    res_parity_s = res_parity_r;
    res_id_s     = res_id_r;
    res_len_s    = res_len_r;
    case (state_r)
      IDLE: begin
        if (any_valid_s) begin
          grant_s    = rr_pick_s;
          in_ready_s = onehot_f(rr_pick_s);
          state_s    = ACCUM;
        end else begin
          in_ready_s = {N_REQ{1'b0}};
        end
      end
      ACCUM: begin
        if (accept_s) begin
          acc_s = acc_nxt_s;
          len_s = len_nxt_s;
          if (bus.in_last[grant_r]) begin
            // Result registers load on the same edge so res_valid rises
            // the cycle after the last byte is accepted.
            state_s      = DONE;
            in_ready_s   = {N_REQ{1'b0}};
            res_valid_s  = 1'b1;
            res_parity_s = acc_nxt_s;
            res_id_s     = grant_r;
            res_len_s    = len_nxt_s;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = ACCUM;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          last_grant_s = grant_r;
          acc_s        = 1'b0;
          len_s        = 8'd0;
          state_s      = IDLE;
          res_valid_s  = 1'b0;
          res_parity_s = 1'b0;
          res_id_s     = 2'd0;
          res_len_s    = 8'd0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s     = IDLE;
        in_ready_s  = {N_REQ{1'b0}};
        res_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      grant_r      <= 2'd0;
      last_grant_r <= 2'(N_REQ - 1);
      acc_r        <= 1'b0;
      len_r        <= 8'd0;
      in_ready_r   <= {N_REQ{1'b0}};
      res_valid_r  <= 1'b0;
      res_parity_r <= 1'b0;
      res_id_r     <= 2'd0;
      res_len_r    <= 8'd0;
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      acc_r        <= acc_s;
      len_r        <= len_s;
      in_ready_r   <= in_ready_s;
      res_valid_r  <= res_valid_s;
      res_parity_r <= res_parity_s;
      res_id_r     <= res_id_s;
      res_len_r    <= res_len_s;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.res_valid  = res_valid_r;
  assign bus.res_parity = res_parity_r;
  assign bus.res_id     = res_id_r;
  assign bus.res_len    = res_len_r;

endmodule

// File: tb/tb_parity_arbiter.sv
// tb_parity_arbiter: directed, table-driven bench for parity_arbiter
// (N_REQ=3, DATA_W=8). Inputs change 1 time unit after a rising edge and
// outputs are checked 1 time unit after the following rising edge.
module tb_parity_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  parity_arbiter_if #(.N_REQ(3), .DATA_W(8)) bus ();

  parity_arbiter #(.N_REQ(3), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [23:0] data;
    logic [2:0]  last;
    logic        rr;
    logic [2:0]  e_ready;
    logic        e_rv;
    logic        e_par;
    logic [1:0]  e_id;
    logic [7:0]  e_len;
  } vec_t;

  vec_t tbl [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [23:0] d, input logic [2:0] l, input logic rr);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.res_ready = rr;
  endtask

  task automatic chk_result(input string name, input logic p, input logic [1:0] id, input logic [7:0] len);
    chk({name, " res_valid"},  32'(bus.res_valid),  32'd1);
    chk({name, " res_parity"}, 32'(bus.res_parity), 32'(p));
    chk({name, " res_id"},     32'(bus.res_id),     32'(id));
    chk({name, " res_len"},    32'(bus.res_len),    32'(len));
  endtask

  task automatic chk_zero(input string name);
    chk({name, " in_ready"},   32'(bus.in_ready),   32'd0);
    chk({name, " res_valid"},  32'(bus.res_valid),  32'd0);
    chk({name, " res_parity"}, 32'(bus.res_parity), 32'd0);
    chk({name, " res_id"},     32'(bus.res_id),     32'd0);
    chk({name, " res_len"},    32'(bus.res_len),    32'd0);
  endtask

  // Watchdog: the stimulus is a fixed number of cycles, this only guards a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] exp_oh;
    logic [7:0] bytes3 [3];
    logic       pars3  [3];
    checks = 0;
    errors = 0;
    bytes3[0] = 8'h01; pars3[0] = 1'b1;
    bytes3[1] = 8'h03; pars3[1] = 1'b0;
    bytes3[2] = 8'h07; pars3[2] = 1'b1;

    // Scenario 1 (req0, 1 byte) and scenario 2 (req1, 3 bytes) as vectors.
    tbl[0] = '{3'b001, 24'h000001, 3'b001, 1'b1, 3'b001, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[1] = '{3'b001, 24'h000001, 3'b001, 1'b1, 3'b000, 1'b1, 1'b1, 2'd0, 8'd1};
    tbl[2] = '{3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[3] = '{3'b010, 24'h000300, 3'b000, 1'b1, 3'b010, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[4] = '{3'b010, 24'h000300, 3'b000, 1'b1, 3'b010, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[5] = '{3'b010, 24'h00AA00, 3'b000, 1'b1, 3'b010, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[6] = '{3'b010, 24'h00FF00, 3'b010, 1'b1, 3'b000, 1'b1, 1'b0, 2'd1, 8'd3};
    tbl[7] = '{3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0};

    // Reset state.
    rst_n = 1'b0;
    drive(3'b000, 24'h000000, 3'b000, 1'b0);
    step();
    step();
    chk_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].rr);
      step();
      chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ready));
      chk($sformatf("vec%0d res_valid", i), 32'(bus.res_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) begin
        chk($sformatf("vec%0d res_parity", i), 32'(bus.res_parity), 32'(tbl[i].e_par));
        chk($sformatf("vec%0d res_id", i), 32'(bus.res_id), 32'(tbl[i].e_id));
        chk($sformatf("vec%0d res_len", i), 32'(bus.res_len), 32'(tbl[i].e_len));
      end
    end

    // Scenario 3: all requesters valid, 1-byte packets -> 0,1,2,0,1,2.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(3'b111, {bytes3[2], bytes3[1], bytes3[0]}, 3'b111, 1'b1);
    for (int p = 0; p < 6; p++) begin
      exp_oh = 3'b000;
      exp_oh[p % 3] = 1'b1;
      step();
      chk($sformatf("rr%0d in_ready", p), 32'(bus.in_ready), 32'(exp_oh));
      step();
      chk_result($sformatf("rr%0d", p), pars3[p % 3], 2'(p % 3), 8'd1);
      step();
      chk($sformatf("rr%0d back_idle", p), 32'(bus.res_valid), 32'd0);
    end

    // Scenario 4: req2 stalls for 5 cycles mid-packet.
    drive(3'b100, 24'h010000, 3'b000, 1'b0);
    step();
    chk("stall grant in_ready", 32'(bus.in_ready), 32'h4);
    step();
    chk("stall byte1 in_ready", 32'(bus.in_ready), 32'h4);
    drive(3'b011, 24'hFF0101, 3'b111, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("stall c%0d in_ready", c), 32'(bus.in_ready), 32'h4);
      chk($sformatf("stall c%0d res_valid", c), 32'(bus.res_valid), 32'd0);
    end
    drive(3'b111, 24'h030101, 3'b100, 1'b0);
    step();
    chk_result("stall", 1'b1, 2'd2, 8'd2);

    // Scenario 5: consumer back-pressure for 4 cycles in DONE.
    for (int c = 0; c < 4; c++) begin
      step();
      chk_result($sformatf("hold c%0d", c), 1'b1, 2'd2, 8'd2);
      chk($sformatf("hold c%0d in_ready", c), 32'(bus.in_ready), 32'd0);
    end
    drive(3'b111, 24'h030101, 3'b111, 1'b1);
    step();
    chk("release res_valid", 32'(bus.res_valid), 32'd0);
    chk("release in_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("release next grant", 32'(bus.in_ready), 32'h1);
    step();
    chk_result("release pkt", 1'b1, 2'd0, 8'd1);
    step();

    // Scenario 6: reset during ACCUM after 2 bytes of a req1 packet.
    drive(3'b010, 24'h000100, 3'b000, 1'b1);
    step();
    chk("rst grant in_ready", 32'(bus.in_ready), 32'h2);
    step();
    step();
    rst_n = 1'b0;
    step();
    chk_zero("mid_rst");
    rst_n = 1'b1;
    drive(3'b111, 24'h010101, 3'b111, 1'b1);
    step();
    chk("post_rst grant", 32'(bus.in_ready), 32'h1);
    step();
    chk_result("post_rst", 1'b1, 2'd0, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_arbiter.md
PARITY_ARBITER -- requirements
Module: parity_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters, range 2..4.
REQ-002 Parameter DATA_W, default 8: byte width per requester.
REQ-003 The port list SHALL be as follows, clock and reset first; one clock; reset is synchronous and active-low:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  N_REQ  per-requester byte valid.
- in_data  input  N_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- in_last  input  N_REQ  per-requester last-byte-of-packet flag.
- in_ready  output  N_REQ  per-requester byte accept.
- res_valid  output  1  packet parity result valid.
- res_ready  input  1  result consumer accept.
- res_parity  output  1  XOR of all bits of all packet bytes (1 = odd count of ones).
- res_id  output  2  index of the requester that owned the packet.
- res_len  output  8  bytes accepted in the packet, saturating at 255.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-005 In IDLE, if any in_valid bit is 1, the FSM SHALL register a grant to one requester and move to ACCUM on the next edge; otherwise it SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin: search starts at index (last_grant+1) mod N_REQ; the first set in_valid bit wins.
REQ-007 in_valid SHALL be sampled for arbitration only in IDLE; changes in other states SHALL NOT affect the current grant.
REQ-008 In ACCUM, in_ready SHALL be 1 only for the granted index and 0 for all others; in IDLE and DONE, in_ready SHALL be all-0.
REQ-009 A byte SHALL be accepted when in_valid[g] and in_ready[g] are both 1; on acceptance: acc <= acc XOR (XOR-reduce of byte); len <= len+1, saturating at 255.
REQ-010 Acceptance with in_last[g]=1 SHALL move the FSM to DONE on the same edge; in_last is ignored when no byte is accepted.
REQ-011 If in_valid[g] drops mid-packet, the FSM SHALL wait in ACCUM indefinitely, with no timeout and acc/len held.
REQ-012 In DONE, res_valid SHALL be 1 and res_parity/res_id/res_len SHALL hold stable until res_ready=1.
REQ-013 When res_valid and res_ready are both 1, the FSM SHALL: set last_grant <= g; clear acc and len; move to IDLE.
REQ-014 Minimum latency SHALL be: a 1-byte packet presented in IDLE at cycle 0 is accepted at cycle 1, with res_valid=1 at cycle 2.
REQ-015 At least one idle cycle SHALL separate consecutive packets; back-to-back grants are not required.

Reset
REQ-016 While rst_n=0 at a rising edge, the block SHALL set:
- state=IDLE, acc=0, len=0, grant=0, last_grant=N_REQ-1 (so requester 0 has first priority).
- res_valid=0, res_parity=0, res_id=0, res_len=0, in_ready all-0.
REQ-017 Reset asserted mid-packet or in DONE SHALL discard the partial packet and result with no residual output.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset release, then req0 sends 1 byte 8'b00000001 with last -> res_valid at cycle 2, res_parity=1, res_id=0, res_len=1.
- req1 sends 3 bytes 8'h03, 8'hAA, 8'hFF (last on third) -> res_parity=0, res_id=1, res_len=3.
- All three requesters valid continuously, 1-byte packets, res_ready=1 -> grant order 0,1,2,0,1,2.
- req2 drops in_valid for 5 cycles mid-packet -> FSM stays in ACCUM, in_ready[2]=1 throughout, acc/len unchanged, and req0/req1 in_ready stay 0.
- res_ready held 0 for 4 cycles in DONE -> outputs stable and no new grant; on res_ready=1, FSM returns to IDLE next cycle.
- rst_n pulsed low during ACCUM after 2 bytes -> all outputs 0 next cycle; next packet len counts from 1 and req0 has priority.
